// File: rtl/r5_pkg.sv
// Shared constants and types for the radix-5 gather path.
// The complex sample type is fixed at R5_DATA_W; DATA_W on the top defaults to it.
package r5_pkg;

  localparam int R5_PTS    = 5;
  localparam int R5_DATA_W = 32;
  localparam int R5_CNT_W  = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } r5_state_e;

  typedef struct packed {
    logic [R5_DATA_W-1:0] re;
    logic [R5_DATA_W-1:0] img;
  } r5_cplx_t;

endpackage

// File: rtl/r5_gather_if.sv
// Sample stream in, 5-point vector out, with valid/ready on both sides.
interface r5_gather_if import r5_pkg::*; #(parameter int DATA_W = R5_DATA_W);

  logic [DATA_W-1:0] a_re;
  logic [DATA_W-1:0] a_img;
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;
  logic [DATA_W-1:0] x0_re;
  logic [DATA_W-1:0] x1_re;
  logic [DATA_W-1:0] x2_re;
  logic [DATA_W-1:0] x3_re;
  logic [DATA_W-1:0] x4_re;
  logic [DATA_W-1:0] x0_img;
  logic [DATA_W-1:0] x1_img;
  logic [DATA_W-1:0] x2_img;
  logic [DATA_W-1:0] x3_img;
  logic [DATA_W-1:0] x4_img;
  logic              out_valid;
  logic              out_ready;
  logic              sync_err;

  modport master (
    output a_re, a_img, in_valid, in_sof, out_ready,
    input  in_ready, out_valid, sync_err,
           x0_re, x1_re, x2_re, x3_re, x4_re,
           x0_img, x1_img, x2_img, x3_img, x4_img
  );

  modport slave (
    input  a_re, a_img, in_valid, in_sof, out_ready,
    output in_ready, out_valid, sync_err,
           x0_re, x1_re, x2_re, x3_re, x4_re,
           x0_img, x1_img, x2_img, x3_img, x4_img
  );

endinterface

// File: rtl/r5_slot_bank.sv
// Five-entry complex register file: one indexed write port, all entries read in parallel.
module r5_slot_bank import r5_pkg::*; (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_we,
  input  logic [R5_CNT_W-1:0]           i_idx,
  input  r5_cplx_t                      i_data,
  output r5_cplx_t [R5_PTS-1:0]         o_slots
);

  r5_cplx_t [R5_PTS-1:0] r_slots;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slots <= '0;
    end else if (i_we && (i_idx < R5_CNT_W'(R5_PTS))) begin
      r_slots[i_idx] <= i_data;
    end
  end

  assign o_slots = r_slots;

endmodule

// File: rtl/r5_gather.sv
// Groups 5 consecutive complex samples into one parallel vector for the radix-5 butterfly.
// A completed group that finds the output busy is parked in the collect bank (HOLD).
module r5_gather import r5_pkg::*; #(
  parameter int DATA_W = R5_DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  r5_gather_if.slave bus
);

  r5_state_e             r_state,     w_state_nxt;
  logic [R5_CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic                  r_sync_err,  w_sync_err_nxt;
  r5_cplx_t [R5_PTS-1:0] r_x,         w_x_nxt;
  r5_cplx_t [R5_PTS-1:0] w_slots;
  r5_cplx_t              w_sample;
  logic                  w_acc;
  logic                  w_xfer;
  logic                  w_free;
  logic                  w_we;
  logic [R5_CNT_W-1:0]   w_idx;

  assign w_sample.re  = R5_DATA_W'(bus.a_re);
  assign w_sample.img = R5_DATA_W'(bus.a_img);

  assign bus.in_ready = !rst && (r_state == COLLECT);
  assign w_acc        = bus.in_valid && bus.in_ready;
  assign w_xfer       = r_out_valid && bus.out_ready;
  assign w_free       = !r_out_valid || bus.out_ready;

  r5_slot_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_data  (w_sample),
    .o_slots (w_slots)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_x         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_sync_err  <= w_sync_err_nxt;
      r_x         <= w_x_nxt;
    end
  end

  // A start-of-group marker always restarts at slot 0; the completing sample bypasses the bank.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_sync_err_nxt  = 1'b0;
    w_x_nxt         = r_x;
    w_we            = 1'b0;
    w_idx           = r_cnt;
    case (r_state)
      COLLECT: begin
        if (w_xfer) begin
          w_out_valid_nxt = 1'b0;
        end
        if (w_acc) begin
          if (bus.in_sof) begin
            w_we           = 1'b1;
            w_idx          = '0;
            w_cnt_nxt      = R5_CNT_W'(1);
            w_sync_err_nxt = (r_cnt != '0);
          end else if (r_cnt < R5_CNT_W'(R5_PTS - 1)) begin
            w_we      = 1'b1;
            w_cnt_nxt = r_cnt + R5_CNT_W'(1);
          end else if (w_free) begin
            w_x_nxt[R5_PTS-2:0] = w_slots[R5_PTS-2:0];
            w_x_nxt[R5_PTS-1]   = w_sample;
            w_out_valid_nxt     = 1'b1;
            w_cnt_nxt           = '0;
          end else begin
            w_we        = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_xfer) begin
          w_x_nxt     = w_slots;
          w_state_nxt = COLLECT;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sync_err  = r_sync_err;
  assign bus.x0_re     = DATA_W'(r_x[0].re);
  assign bus.x1_re     = DATA_W'(r_x[1].re);
  assign bus.x2_re     = DATA_W'(r_x[2].re);
  assign bus.x3_re     = DATA_W'(r_x[3].re);
  assign bus.x4_re     = DATA_W'(r_x[4].re);
  assign bus.x0_img    = DATA_W'(r_x[0].img);
  assign bus.x1_img    = DATA_W'(r_x[1].img);
  assign bus.x2_img    = DATA_W'(r_x[2].img);
  assign bus.x3_img    = DATA_W'(r_x[3].img);
  assign bus.x4_img    = DATA_W'(r_x[4].img);

endmodule

// File: tb/tb_r5_gather.sv
// Bench for r5_gather: directed scenarios then random traffic, all checked against a
// queue-based model of pending groups and presented vectors.
module tb_r5_gather;
  import r5_pkg::*;

  typedef logic [63:0]        slot_t;
  typedef logic [5*64-1:0]    vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  r5_gather_if #(.DATA_W(32)) bus();

  r5_gather #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  slot_t cur[$];
  vec_t  outQ[$];
  bit    expSyncErr = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic slot_t dutSlot(input int i);
    case (i)
      0:       dutSlot = {bus.x0_re, bus.x0_img};
      1:       dutSlot = {bus.x1_re, bus.x1_img};
      2:       dutSlot = {bus.x2_re, bus.x2_img};
      3:       dutSlot = {bus.x3_re, bus.x3_img};
      default: dutSlot = {bus.x4_re, bus.x4_img};
    endcase
  endfunction

  // The model tracks the partial group and the queue of completed-but-unconsumed vectors.
  // Two pending vectors means both output and collect storage are occupied.
  task automatic applyStimulus(input logic v, input logic sof, input logic [31:0] re,
                               input logic [31:0] im, input logic ro);
    logic  expReady;
    logic  expValid;
    vec_t  front;
    vec_t  nv;
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = v;
    bus.in_sof    = sof;
    bus.a_re      = re;
    bus.a_img     = im;
    bus.out_ready = ro;
    #1;
    expReady = (outQ.size() < 2);
    expValid = (outQ.size() >= 1);
    checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(expValid));
    checkOutput("sync_err", 64'(bus.sync_err), 64'(expSyncErr));
    if (expValid) begin
      front = outQ[0];
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("x%0d", i), dutSlot(i), front[i*64 +: 64]);
      end
    end
    if (expValid && ro) begin
      void'(outQ.pop_front());
    end
    expSyncErr = 1'b0;
    if (v && expReady) begin
      if (sof) begin
        expSyncErr = (cur.size() != 0);
        cur.delete();
        cur.push_back({re, im});
      end else begin
        cur.push_back({re, im});
        if (cur.size() == 5) begin
          for (int i = 0; i < 5; i++) begin
            nv[i*64 +: 64] = cur[i];
          end
          outQ.push_back(nv);
          cur.delete();
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_sof    = 1'($urandom_range(1));
      bus.a_re      = $urandom;
      bus.a_img     = $urandom;
      bus.out_ready = 1'b1;
      #1;
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
      if (i > 0) begin
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_sync_err", 64'(bus.sync_err), 64'd0);
        for (int k = 0; k < 5; k++) begin
          checkOutput($sformatf("rst_x%0d", k), dutSlot(k), 64'd0);
        end
      end
      @(posedge clk);
    end
    cur.delete();
    outQ.delete();
    expSyncErr = 1'b0;
  endtask

  task automatic idle(input int n, input logic ro);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, ro);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.a_re      = '0;
    bus.a_img     = '0;
    bus.out_ready = 1'b0;
    doReset(3);

    $display("[TB] streaming 10 samples with out_ready high");
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b0, 32'(i), 32'(-i), 1'b1);
    idle(3, 1'b1);

    $display("[TB] 10 samples with out_ready low, then release");
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b0, 32'(i), 32'(-i), 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd55, 32'd66, 1'b0);
    idle(3, 1'b1);

    $display("[TB] start-of-group after partial group");
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 32'(i), 32'(-i), 1'b1);
    applyStimulus(1'b1, 1'b1, 32'd100, 32'(-100), 1'b1);
    for (int i = 101; i <= 104; i++) applyStimulus(1'b1, 1'b0, 32'(i), 32'(-i), 1'b1);
    idle(3, 1'b1);

    $display("[TB] back-to-back completion and transfer");
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b0, 32'(i), 32'(-i), 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd10, 32'(-10), 1'b1);
    idle(3, 1'b1);

    $display("[TB] reset in the middle of a group");
    for (int i = 1; i <= 2; i++) applyStimulus(1'b1, 1'b0, 32'(i), 32'(-i), 1'b1);
    doReset(2);
    for (int i = 7; i <= 11; i++) applyStimulus(1'b1, 1'b0, 32'(i), 32'(-i), 1'b1);
    idle(3, 1'b1);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) doReset(2);
      applyStimulus($urandom_range(3) != 0, $urandom_range(15) == 0,
                    $urandom, $urandom, $urandom_range(7) < 5);
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/r5_gather.md
Name: r5_gather

Overview:
- Serial-to-parallel collector for the radix-5 FFT datapath.
- Sits directly downstream of the complex delay-line buffers. It consumes one complex sample per accepted cycle and groups 5 consecutive samples into one parallel 5-point vector (x0..x4) for the radix-5 butterfly.
- Provides valid/ready handshaking on both sides.
- Double-buffered: a new group can be collected while the previous group waits for the butterfly.

Parameters:
- DATA_W, 32, width of each real and imaginary component (two's complement, passed through unmodified).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a_re  in  DATA_W  real part of the incoming sample.
- a_img  in  DATA_W  imaginary part of the incoming sample.
- in_valid  in  1  the incoming sample is valid.
- in_sof  in  1  start-of-group marker; qualified by in_valid.
- in_ready  out  1  the collector can accept a sample this cycle.
- x0_re, x1_re, x2_re, x3_re, x4_re  out  DATA_W each  real parts of the grouped samples; x0 is the oldest.
- x0_img, x1_img, x2_img, x3_img, x4_img  out  DATA_W each  imaginary parts of the grouped samples.
- out_valid  out  1  the x0..x4 vector is valid.
- out_ready  in  1  the butterfly accepts the vector.
- sync_err  out  1  one-cycle pulse: a partial group was discarded.

Behaviour:
- Handshakes:
  - Input accept: acc = in_valid && in_ready.
  - Output transfer: xfer = out_valid && out_ready.
- Reset (rst high at an edge), from any state including mid-group:
  - slot_cnt=0, state=COLLECT, out_valid=0, sync_err=0.
  - All x*_re/x*_img = 0 and all collect slots = 0.
  - in_ready=0 while rst is high.
- in_ready = !rst && (state==COLLECT). It is combinational from state only, never from out_ready.
- Collect bank: slots s0..s4, slot_cnt in 0..4.
- acc with slot_cnt<4 and !in_sof:
  - s[slot_cnt] <= sample; slot_cnt++.
- acc with in_sof:
  - If slot_cnt!=0: partial group discarded, sample written to s0, slot_cnt<=1, sync_err pulses high next cycle for exactly 1 cycle.
  - If slot_cnt==0: treated as a normal write to s0, no error.
- acc with slot_cnt==4 and !in_sof (completing sample):
  - Output bank free (out_valid==0 || out_ready==1): x0..x3 <= s0..s3, x4 <= sample, out_valid<=1, slot_cnt<=0, state stays COLLECT.
  - Latency: out_valid is high the cycle after the 5th sample is accepted.
  - Output bank busy: s4 <= sample, state<=HOLD, slot_cnt<=0.
- HOLD (in_ready=0):
  - On xfer: x0..x4 <= s0..s4, out_valid stays 1, state<=COLLECT.
  - A held group reaches the output 1 cycle after the blocking vector is consumed.
- xfer in COLLECT with no completing sample: out_valid<=0 and data held.
- Output data is stable while out_valid && !out_ready. This must be assertable.
- Simultaneous xfer and completing acc in the same cycle: the new vector replaces the old one; out_valid stays 1 with no bubble.
- Sustained throughput: 5 samples per vector, one vector per 5 cycles with no stalls.
- No arithmetic is performed; data widths pass through unchanged.

Decomposition:
- Shared package r5_pkg:
  - R5_PTS=5, the constant that fixes the slot count.
  - State encoding COLLECT/HOLD.
  - Complex struct/typedef {re, img} of DATA_W.
- One natural sub-module: r5_slot_bank. It is the 5-entry complex register file with a write index and a parallel read, instantiated once for collect storage.

Test Plan:
- Reset, then in_valid held high with samples re=1..10, img=-1..-10, out_ready=1 -> out_valid pulses in the cycles after samples 5 and 10; first vector x0..x4_re = 1,2,3,4,5 and img = -1..-5; second vector re = 6..10; in_ready always 1.
- out_ready=0, 10 samples re=1..10 streamed -> vector 1..5 presented and held; in_ready drops the cycle after sample 10 is accepted; raising out_ready -> vector 1..5 transfers, vector 6..10 appears next cycle, in_ready returns to 1.
- 3 samples re=1,2,3, then in_sof with re=100, then re=101..104 -> sync_err pulses 1 cycle; output vector = 100,101,102,103,104.
- Back-to-back: 5th sample accepted in the same cycle as xfer of the previous vector -> new vector with no idle out_valid cycle; data changes only on the xfer edge.
- rst asserted after 2 samples, then 5 samples re=7..11 -> first output vector = 7..11 and no sync_err; all outputs 0 and out_valid 0 during reset.
